cv_spinner_quad: RTL and testbench



---
 rtl/cv_spinner_pkg.sv | 39 +++
 rtl/cv_spinner_quad_if.sv | 20 ++
 rtl/cv_spinner_chan.sv | 62 ++++++
 rtl/cv_spinner_quad.sv | 69 ++++++
 tb/tb_cv_spinner_quad.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv_spinner_pkg.sv
// Shared Gray-phase type and saturating arithmetic for the Colecovision spinner encoder.
package cv_spinner_pkg;

    localparam int ACC_W   = 10;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));

    // {quad_a, quad_b}
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_01 = 2'b01,
        PH_11 = 2'b11,
        PH_10 = 2'b10
    } quad_phase_t;

    function automatic quad_phase_t gray_next(input quad_phase_t phase, input logic dir_fwd);
        quad_phase_t r;
        case (phase)
            PH_00:   r = dir_fwd ? PH_01 : PH_10;
            PH_01:   r = dir_fwd ? PH_11 : PH_00;
            PH_11:   r = dir_fwd ? PH_10 : PH_01;
            default: r = dir_fwd ? PH_00 : PH_11;
        endcase
        return r;
    endfunction

    function automatic int sat_add(input int acc, input int delta,
                                   input int hi = ACC_MAX, input int lo = ACC_MIN);
        int sum;
        sum = acc + delta;
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        else
            return sum;
    endfunction

endpackage

// File: rtl/cv_spinner_quad_if.sv
// Host-side delta bus and per-player quadrature outputs of the spinner encoder.
interface cv_spinner_quad_if;
    logic              clk_en_3m58_i;
    logic [2:1]        delta_stb_i;
    logic signed [7:0] delta_p1_i;
    logic signed [7:0] delta_p2_i;
    logic [2:1]        quad_a_o;
    logic [2:1]        quad_b_o;
    logic [2:1]        busy_o;

    modport master (
        output clk_en_3m58_i, delta_stb_i, delta_p1_i, delta_p2_i,
        input  quad_a_o, quad_b_o, busy_o
    );

    modport slave (
        input  clk_en_3m58_i, delta_stb_i, delta_p1_i, delta_p2_i,
        output quad_a_o, quad_b_o, busy_o
    );
endinterface

// File: rtl/cv_spinner_chan.sv
// One player: saturating motion accumulator replayed as paced Gray-code quadrature steps.
// Latency: phase changes one clk_i after the STEP_DIV-th enable tick; delta capture every clk_i.
// Backpressure: none; excess motion saturates the accumulator.
module cv_spinner_chan
    import cv_spinner_pkg::*;
#(
    parameter int ACC_W    = 10,
    parameter int STEP_DIV = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic              delta_stb_i,
    input  logic signed [7:0] delta_i,
    output logic              quad_a_o,
    output logic              quad_b_o,
    output logic              busy_o
);
    localparam int               TMR_W    = $clog2(STEP_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_DIV - 1);
    localparam int               LIM_HI   = (1 << (ACC_W - 1)) - 1;
    localparam int               LIM_LO   = -(1 << (ACC_W - 1));

    logic [TMR_W-1:0]        r_tmr;
    logic signed [ACC_W-1:0] r_acc;
    quad_phase_t             r_phase;

    logic                    w_wrap;
    logic                    w_step;
    logic                    w_fwd;
    int                      w_acc_base;
    int                      w_delta;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_wrap = clk_en_i && (r_tmr == TMR_LAST);
    assign w_step = w_wrap && (r_acc != '0);
    assign w_fwd  = !r_acc[ACC_W-1];

    // A step consumes one unit before the new delta lands, so a same-cycle strobe sums correctly.
    assign w_acc_base = int'(r_acc) - (w_step ? (w_fwd ? 1 : -1) : 0);
    assign w_delta    = delta_stb_i ? int'(delta_i) : 0;
    assign w_acc_next = ACC_W'(sat_add(w_acc_base, w_delta, LIM_HI, LIM_LO));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tmr   <= '0;
            r_acc   <= '0;
            r_phase <= PH_00;
        end else begin
            r_acc <= w_acc_next;
            if (clk_en_i)
                r_tmr <= w_wrap ? '0 : r_tmr + TMR_W'(1);
            if (w_step)
                r_phase <= gray_next(r_phase, w_fwd);
        end
    end

    assign quad_a_o = r_phase[1];
    assign quad_b_o = r_phase[0];
    assign busy_o   = (r_acc != '0);

endmodule

// File: rtl/cv_spinner_quad.sv
// Two-player Colecovision spinner encoder; CV_SPINNER_SCALE_EN enables delta down-scaling.
// Latency: delta captured next clk_i; steps paced every STEP_DIV clk_en_3m58_i ticks.
// Backpressure: none; accumulators saturate at ACC_W signed limits.
module cv_spinner_quad
    import cv_spinner_pkg::*;
#(
    parameter int ACC_W       = 10,
    parameter int STEP_DIV    = 64,
    parameter int DELTA_SHIFT = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    cv_spinner_quad_if.slave   bus
);
    if (STEP_DIV < 2 || STEP_DIV > 1023) begin : g_bad_div
        $error("cv_spinner_quad: STEP_DIV out of range");
    end
    if (DELTA_SHIFT < 0 || DELTA_SHIFT > 7) begin : g_bad_shift
        $error("cv_spinner_quad: DELTA_SHIFT out of range");
    end

    // Biasing negatives before the arithmetic shift makes the division round toward zero.
    function automatic logic signed [7:0] scale_delta(input logic signed [7:0] d);
`ifdef CV_SPINNER_SCALE_EN
        int v;
        v = int'(d);
        if (v < 0)
            v = v + ((1 << DELTA_SHIFT) - 1);
        return 8'(v >>> DELTA_SHIFT);
`else
        return d;
`endif
    endfunction

    logic signed [7:0] w_d1;
    logic signed [7:0] w_d2;

    assign w_d1 = scale_delta(bus.delta_p1_i);
    assign w_d2 = scale_delta(bus.delta_p2_i);

    cv_spinner_chan #(
        .ACC_W    (ACC_W),
        .STEP_DIV (STEP_DIV)
    ) u_chan_p1 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (bus.clk_en_3m58_i),
        .delta_stb_i (bus.delta_stb_i[1]),
        .delta_i     (w_d1),
        .quad_a_o    (bus.quad_a_o[1]),
        .quad_b_o    (bus.quad_b_o[1]),
        .busy_o      (bus.busy_o[1])
    );

    cv_spinner_chan #(
        .ACC_W    (ACC_W),
        .STEP_DIV (STEP_DIV)
    ) u_chan_p2 (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .clk_en_i    (bus.clk_en_3m58_i),
        .delta_stb_i (bus.delta_stb_i[2]),
        .delta_i     (w_d2),
        .quad_a_o    (bus.quad_a_o[2]),
        .quad_b_o    (bus.quad_b_o[2]),
        .busy_o      (bus.busy_o[2])
    );

endmodule

// File: tb/tb_cv_spinner_quad.sv
// Scoreboard bench for cv_spinner_quad: expected Gray steps queued at stimulus, popped on each phase change.
`timescale 1ns/1ps
module tb_cv_spinner_quad;
    localparam int STEP_DIV = 4;
`ifdef CV_SPINNER_SCALE_EN
    localparam bit SCALED = 1'b1;
`else
    localparam bit SCALED = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic reset_i;
    cv_spinner_quad_if bus();

    cv_spinner_quad #(.ACC_W(10), .STEP_DIV(STEP_DIV), .DELTA_SHIFT(1)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] ph;
        logic       busy;
        int         gap;
        int         at_tick;
    } exp_t;

    exp_t       q1[$];
    exp_t       q2[$];
    int         checks = 0;
    int         errors = 0;
    int         tick_cnt = 0;
    int         tick_idx = 0;
    int         div = 0;
    logic       rst_req = 1'b1;
    logic [1:0] mph [1:2];
    int         macc [1:2];
    int         steps [1:2];
    int         last_tick [1:2];
    logic [1:0] last_ph [1:2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic int pick(input int unscaled, input int scaled);
        return SCALED ? scaled : unscaled;
    endfunction

    function automatic int msat(input int v);
        return (v > 511) ? 511 : ((v < -512) ? -512 : v);
    endfunction

    function automatic int mscale(input int d);
        if (!SCALED) return d;
        return (d < 0) ? -((-d) >> 1) : (d >> 1);
    endfunction

    function automatic logic [1:0] mgray(input logic [1:0] ph, input logic fwd);
        case (ph)
            2'b00:   return fwd ? 2'b01 : 2'b10;
            2'b01:   return fwd ? 2'b11 : 2'b00;
            2'b11:   return fwd ? 2'b10 : 2'b01;
            default: return fwd ? 2'b00 : 2'b11;
        endcase
    endfunction

    // One clk_i of stimulus; enable is issued every third cycle unless suppressed.
    task automatic cyc(input logic allow_en, input logic [2:1] stb,
                       input logic signed [7:0] d1, input logic signed [7:0] d2);
        @(negedge clk_i);
        reset_i = rst_req;
        bus.clk_en_3m58_i = allow_en && (div == 2);
        div = (div == 2) ? 0 : div + 1;
        if (reset_i)
            tick_idx = 0;
        else if (bus.clk_en_3m58_i) begin
            tick_cnt++;
            tick_idx++;
        end
        bus.delta_stb_i = stb;
        bus.delta_p1_i  = d1;
        bus.delta_p2_i  = d2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 2'b00, 8'sd0, 8'sd0);
    endtask

    task automatic strobe(input logic en, input logic [2:1] stb, input int d1, input int d2);
        cyc(en, stb, 8'(d1), 8'(d2));
        if (stb[1]) macc[1] = msat(macc[1] + mscale(d1));
        if (stb[2]) macc[2] = msat(macc[2] + mscale(d2));
    endtask

    task automatic flush(input int p, input int at_first);
        int   n;
        logic fwd;
        exp_t e;
        n   = (macc[p] < 0) ? -macc[p] : macc[p];
        fwd = (macc[p] > 0);
        for (int i = 0; i < n; i++) begin
            mph[p]    = mgray(mph[p], fwd);
            e.ph      = mph[p];
            e.busy    = (i != n - 1);
            e.gap     = (i == 0) ? -1 : STEP_DIV;
            e.at_tick = (i == 0) ? at_first : -1;
            if (p == 1) q1.push_back(e);
            else        q2.push_back(e);
        end
        macc[p] = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0 || bus.busy_o != 2'b00) && n < budget) begin
            idle(1);
            n++;
        end
        chk({name, "_done_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    function automatic logic [1:0] phase_of(input int p);
        return {bus.quad_a_o[p], bus.quad_b_o[p]};
    endfunction

    // Monitor: every phase change must match the head of that player's queue.
    initial begin
        logic [1:0] cur;
        exp_t       e;
        for (int p = 1; p <= 2; p++) begin
            last_ph[p] = 2'b00;
            last_tick[p] = 0;
        end
        forever begin
            @(posedge clk_i);
            #1;
            for (int p = 1; p <= 2; p++) begin
                cur = phase_of(p);
                if (reset_i) begin
                    last_ph[p] = cur;
                end else if (cur != last_ph[p]) begin
                    steps[p]++;
                    if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_step_p%0d: phase %b -> %b with nothing queued", p, last_ph[p], cur);
                    end else begin
                        e = (p == 1) ? q1.pop_front() : q2.pop_front();
                        chk($sformatf("phase_p%0d", p), 32'(cur), 32'(e.ph));
                        chk($sformatf("busy_at_step_p%0d", p), 32'(bus.busy_o[p]), 32'(e.busy));
                        if (e.gap >= 0)
                            chk($sformatf("step_gap_p%0d", p), tick_cnt - last_tick[p], e.gap);
                        if (e.at_tick >= 0)
                            chk($sformatf("step_tick_p%0d", p), tick_cnt, e.at_tick);
                    end
                    last_tick[p] = tick_cnt;
                    last_ph[p]   = cur;
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int d_a;
        int d_b;
        reset_i = 1'b1;
        bus.clk_en_3m58_i = 1'b0;
        bus.delta_stb_i = 2'b00;
        bus.delta_p1_i = 8'sd0;
        bus.delta_p2_i = 8'sd0;
        for (int p = 1; p <= 2; p++) begin
            mph[p] = 2'b00;
            macc[p] = 0;
            steps[p] = 0;
        end

        // Reset state
        idle(3);
        chk("reset_quad_a", 32'(bus.quad_a_o), 32'd0);
        chk("reset_quad_b", 32'(bus.quad_b_o), 32'd0);
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        rst_req = 1'b0;
        idle(5);

        // Forward motion on player 1
        steps[1] = 0; steps[2] = 0;
        strobe(1'b1, 2'b01, 3, 0);
        flush(1, -1);
        @(posedge clk_i); #1;
        chk("fwd_busy_p1_set", 32'(bus.busy_o[1]), 32'd1);
        chk("fwd_busy_p2_clear", 32'(bus.busy_o[2]), 32'd0);
        wait_idle("fwd", 300);
        chk("fwd_steps_p1", steps[1], pick(3, 1));
        chk("fwd_steps_p2", steps[2], 0);
        chk("fwd_phase_p1", 32'(phase_of(1)), pick(2'b10, 2'b01));

        // Reverse motion on player 2
        steps[1] = 0; steps[2] = 0;
        strobe(1'b1, 2'b10, 0, -2);
        flush(2, -1);
        wait_idle("rev", 300);
        chk("rev_steps_p2", steps[2], pick(2, 1));
        chk("rev_phase_p2", 32'(phase_of(2)), pick(2'b11, 2'b10));
        chk("rev_steps_p1", steps[1], 0);

        // Opposing deltas sum algebraically
        steps[2] = 0;
        strobe(1'b0, 2'b10, 0, 2);
        strobe(1'b0, 2'b10, 0, -5);
        flush(2, -1);
        wait_idle("sum", 300);
        chk("sum_steps_p2", steps[2], pick(3, 1));
        chk("sum_phase_p2", 32'(phase_of(2)), pick(2'b10, 2'b11));

        // Saturation: +127 x5 on player 1, -128 x5 on player 2
        steps[1] = 0; steps[2] = 0;
        repeat (5) strobe(1'b0, 2'b11, 127, -128);
        flush(1, -1);
        flush(2, -1);
        wait_idle("sat", 8000);
        chk("sat_steps_p1", steps[1], pick(511, 315));
        chk("sat_steps_p2", steps[2], pick(512, 320));
        chk("sat_phase_p1", 32'(phase_of(1)), pick(2'b11, 2'b00));
        chk("sat_phase_p2", 32'(phase_of(2)), pick(2'b10, 2'b11));

        // Strobe landing on the wrap tick of a pending single step
        steps[1] = 0;
        d_a = pick(1, 2);
        d_b = pick(5, 10);
        n = 0;
        do begin idle(1); n++; end
        while (!(bus.clk_en_3m58_i && (tick_idx % STEP_DIV) == 0) && n < 100);
        chk("sim_find_wrap", 32'(n < 100), 32'd1);
        strobe(1'b1, 2'b01, d_a, 0);
        n = 0;
        while (!(div == 2 && (tick_idx % STEP_DIV) == STEP_DIV - 1) && n < 100) begin
            idle(1);
            n++;
        end
        chk("sim_align_wrap", 32'(n < 100), 32'd1);
        strobe(1'b1, 2'b01, d_b, 0);
        flush(1, tick_cnt);
        @(posedge clk_i); #1;
        chk("sim_busy_after_wrap", 32'(bus.busy_o[1]), 32'd1);
        chk("sim_steps_at_wrap", steps[1], 1);
        wait_idle("sim", 300);
        chk("sim_steps_p1", steps[1], 6);
        chk("sim_phase_p1", 32'(phase_of(1)), pick(2'b00, 2'b11));

        // Small deltas, which scaling rounds toward zero
        steps[2] = 0;
        strobe(1'b1, 2'b10, 0, 1);
        flush(2, -1);
        @(posedge clk_i); #1;
        chk("small_busy_p2", 32'(bus.busy_o[2]), pick(1, 0));
        wait_idle("small_pos", 300);
        chk("small_pos_steps_p2", steps[2], pick(1, 0));
        steps[2] = 0;
        strobe(1'b1, 2'b10, 0, -7);
        flush(2, -1);
        wait_idle("small_neg", 300);
        chk("small_neg_steps_p2", steps[2], pick(7, 3));
        chk("small_neg_phase_p2", 32'(phase_of(2)), pick(2'b01, 2'b10));

        // Reset in the middle of a long run
        steps[1] = 0;
        strobe(1'b1, 2'b01, 20, 0);
        flush(1, -1);
        n = 0;
        while (steps[1] < 3 && n < 500) begin
            idle(1);
            n++;
        end
        chk("mid_reach_steps", 32'(n < 500), 32'd1);
        rst_req = 1'b1;
        idle(1);
        #1;
        chk("mid_reset_quad_a", 32'(bus.quad_a_o), 32'd0);
        chk("mid_reset_quad_b", 32'(bus.quad_b_o), 32'd0);
        chk("mid_reset_busy", 32'(bus.busy_o), 32'd0);
        q1.delete();
        q2.delete();
        for (int p = 1; p <= 2; p++) begin
            mph[p] = 2'b00;
            macc[p] = 0;
        end
        idle(2);
        rst_req = 1'b0;
        idle(1);
        steps[1] = 0; steps[2] = 0;
        idle(60);
        chk("post_reset_busy", 32'(bus.busy_o), 32'd0);
        chk("post_reset_steps_p1", steps[1], 0);
        chk("post_reset_steps_p2", steps[2], 0);

        chk("final_queue_p1", q1.size(), 0);
        chk("final_queue_p2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
